// File: rtl/fft_pkg.sv
// Shared definitions for the MDC FFT pipeline stages.
//   cplx_t     : complex sample at the default pipeline width
//   DEF_*      : default sizes and clog2-derived widths
//   quant_tw   : round-to-nearest quantizer for twiddle components
//   round_sat  : add half-LSB, arithmetic shift, saturate to out_w bits
package fft_pkg;

    localparam int DEF_FFT_N  = 64;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_CNT_W  = $clog2(DEF_FFT_N / 2);

    localparam real PI = 3.14159265358979323846;

    typedef struct packed {
        logic signed [DEF_DATA_W-1:0] re;
        logic signed [DEF_DATA_W-1:0] im;
    } cplx_t;

    // Scales v to Q1.(tw_w-1), rounds half away from zero, and clamps so
    // that +1.0 lands on the largest positive code while -1.0 stays exact.
    function automatic longint quant_tw(input real v, input int tw_w);
        real    s;
        real    r;
        longint q;
        longint hi;
        s  = v * (2.0 ** (tw_w - 1));
        r  = (s >= 0.0) ? $floor(s + 0.5) : -$floor(-s + 0.5);
        q  = $rtoi(r);
        hi = (longint'(1) << (tw_w - 1)) - 1;
        if (q > hi)
            q = hi;
        if (q < -hi - 1)
            q = -hi - 1;
        return q;
    endfunction

    function automatic longint round_sat(input longint x, input int shift, input int out_w);
        longint r;
        longint hi;
        longint lo;
        r  = (x + (longint'(1) << (shift - 1))) >>> shift;
        hi = (longint'(1) << (out_w - 1)) - 1;
        lo = -(longint'(1) << (out_w - 1));
        if (r > hi)
            r = hi;
        if (r < lo)
            r = lo;
        return r;
    endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Twiddle factor ROM W(k) = cos(2*pi*k/N) - j*sin(2*pi*k/N), k < N/2.
//   clk, reset (async, active-low), enable (holds the output register)
//   addr        : twiddle index k
//   w_re, w_im  : registered twiddle, Q1.(TW_WIDTH-1), one cycle after addr
module twiddle_rom
    import fft_pkg::*;
#(
    parameter int FFT_N    = 64,
    parameter int TW_WIDTH = 16,
    localparam int AW      = $clog2(FFT_N / 2)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [AW-1:0]              addr,
    output logic signed [TW_WIDTH-1:0] w_re,
    output logic signed [TW_WIDTH-1:0] w_im
);

    logic signed [TW_WIDTH-1:0] rom_re [FFT_N/2];
    logic signed [TW_WIDTH-1:0] rom_im [FFT_N/2];

    for (genvar i = 0; i < FFT_N / 2; i++) begin : g_rom
        localparam real    ANG  = 2.0 * PI * real'(i) / real'(FFT_N);
        localparam longint RE_Q = quant_tw($cos(ANG), TW_WIDTH);
        localparam longint IM_Q = quant_tw(-$sin(ANG), TW_WIDTH);
        assign rom_re[i] = TW_WIDTH'(RE_Q);
        assign rom_im[i] = TW_WIDTH'(IM_Q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_re <= '0;
            w_im <= '0;
        end else if (enable) begin
            w_re <= rom_re[addr];
            w_im <= rom_im[addr];
        end
    end

endmodule

// File: rtl/mdc_butterfly_stage.sv
// Radix-2 DIF butterfly with twiddle multiply for one MDC FFT stage.
//   clk, reset (async, active-low), enable (global hold)
//   in_valid, x0_*, x1_*  : input pair
//   y0_* = (x0+x1)/2, y1_* = ((x0-x1)/2)*W, three cycles after input
//   out_valid, out_last   : output qualifiers; out_last marks pair N/2-1
module mdc_butterfly_stage
    import fft_pkg::*;
#(
    parameter int FFT_N      = 64,
    parameter int STAGE      = 0,
    parameter int DATA_WIDTH = 16,
    parameter int TW_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] x0_re,
    input  logic signed [DATA_WIDTH-1:0] x0_im,
    input  logic signed [DATA_WIDTH-1:0] x1_re,
    input  logic signed [DATA_WIDTH-1:0] x1_im,
    output logic signed [DATA_WIDTH-1:0] y0_re,
    output logic signed [DATA_WIDTH-1:0] y0_im,
    output logic signed [DATA_WIDTH-1:0] y1_re,
    output logic signed [DATA_WIDTH-1:0] y1_im,
    output logic                         out_valid,
    output logic                         out_last
);

    localparam int CNT_W = $clog2(FFT_N / 2);
    localparam int PW    = DATA_WIDTH + TW_WIDTH + 1;

    // Twiddle period at this stage is N>>(STAGE+1); a power of two, so a mask.
    localparam logic [CNT_W-1:0] K_MASK = CNT_W'((FFT_N >> (STAGE + 1)) - 1);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(FFT_N / 2 - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] k;

    logic signed [DATA_WIDTH:0]   sum_re, sum_im, dif_re, dif_im;
    logic signed [DATA_WIDTH-1:0] a_re_p1, a_im_p1, b_re_p1, b_im_p1;
    logic signed [TW_WIDTH-1:0]   w_re_p1, w_im_p1;
    logic                         vld_p1, last_p1;

    logic signed [PW-1:0]         pr_c, pi_c;
    logic signed [DATA_WIDTH-1:0] a_re_p2, a_im_p2;
    logic signed [PW-1:0]         pr_p2, pi_p2;
    logic                         vld_p2, last_p2;

    logic                         vld_p3, last_p3;
    longint                       y1_re_c, y1_im_c;

    assign k = (cnt & K_MASK) << STAGE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (enable && in_valid)
            cnt <= cnt + CNT_W'(1);
    end

    twiddle_rom #(
        .FFT_N    (FFT_N),
        .TW_WIDTH (TW_WIDTH)
    ) u_rom (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .addr   (k),
        .w_re   (w_re_p1),
        .w_im   (w_im_p1)
    );

    // S1: half-scaled sum and difference; one extra bit so nothing wraps.
    always_comb begin
        sum_re = {x0_re[DATA_WIDTH-1], x0_re} + {x1_re[DATA_WIDTH-1], x1_re};
        sum_im = {x0_im[DATA_WIDTH-1], x0_im} + {x1_im[DATA_WIDTH-1], x1_im};
        dif_re = {x0_re[DATA_WIDTH-1], x0_re} - {x1_re[DATA_WIDTH-1], x1_re};
        dif_im = {x0_im[DATA_WIDTH-1], x0_im} - {x1_im[DATA_WIDTH-1], x1_im};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_re_p1 <= '0;
            a_im_p1 <= '0;
            b_re_p1 <= '0;
            b_im_p1 <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else if (enable) begin
            a_re_p1 <= sum_re[DATA_WIDTH:1];
            a_im_p1 <= sum_im[DATA_WIDTH:1];
            b_re_p1 <= dif_re[DATA_WIDTH:1];
            b_im_p1 <= dif_im[DATA_WIDTH:1];
            vld_p1  <= in_valid;
            last_p1 <= in_valid && (cnt == LAST);
        end
    end

    // S2: full-precision complex multiply b * W.
    always_comb begin
        pr_c = PW'(b_re_p1) * PW'(w_re_p1) - PW'(b_im_p1) * PW'(w_im_p1);
        pi_c = PW'(b_re_p1) * PW'(w_im_p1) + PW'(b_im_p1) * PW'(w_re_p1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_re_p2 <= '0;
            a_im_p2 <= '0;
            pr_p2   <= '0;
            pi_p2   <= '0;
            vld_p2  <= 1'b0;
            last_p2 <= 1'b0;
        end else if (enable) begin
            a_re_p2 <= a_re_p1;
            a_im_p2 <= a_im_p1;
            pr_p2   <= pr_c;
            pi_p2   <= pi_c;
            vld_p2  <= vld_p1;
            last_p2 <= last_p1;
        end
    end

    // S3: drop the Q1.(TW_WIDTH-1) fraction with rounding and saturation.
    always_comb begin
        y1_re_c = round_sat(longint'(pr_p2), TW_WIDTH - 1, DATA_WIDTH);
        y1_im_c = round_sat(longint'(pi_p2), TW_WIDTH - 1, DATA_WIDTH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y0_re   <= '0;
            y0_im   <= '0;
            y1_re   <= '0;
            y1_im   <= '0;
            vld_p3  <= 1'b0;
            last_p3 <= 1'b0;
        end else if (enable) begin
            y0_re   <= a_re_p2;
            y0_im   <= a_im_p2;
            y1_re   <= DATA_WIDTH'(y1_re_c);
            y1_im   <= DATA_WIDTH'(y1_im_c);
            vld_p3  <= vld_p2;
            last_p3 <= last_p2;
        end
    end

    // The tags are held during a stall but must not be presented as new data.
    assign out_valid = vld_p3 & enable;
    assign out_last  = last_p3 & vld_p3 & enable;

endmodule

// File: tb/tb_mdc_butterfly_stage.sv
module tb_mdc_butterfly_stage;

    localparam int N  = 64;
    localparam int DW = 16;
    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic in_valid;
    logic signed [DW-1:0] x0_re, x0_im, x1_re, x1_im;
    logic signed [DW-1:0] a_y0_re, a_y0_im, a_y1_re, a_y1_im;
    logic signed [DW-1:0] b_y0_re, b_y0_im, b_y1_re, b_y1_im;
    logic a_valid, a_last, b_valid, b_last;

    int n_assert = 0;
    int n_fail   = 0;
    int mcnt     = 0;

    typedef struct {
        bit vld;
        bit last;
        int y0r, y0i, y1r, y1i, s5r, s5i, tol;
    } ent_t;

    ent_t pipe [3];

    always #5 clk = ~clk;

    mdc_butterfly_stage #(.FFT_N(N), .STAGE(0), .DATA_WIDTH(DW), .TW_WIDTH(16)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
        .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im),
        .y0_re(a_y0_re), .y0_im(a_y0_im), .y1_re(a_y1_re), .y1_im(a_y1_im),
        .out_valid(a_valid), .out_last(a_last)
    );

    mdc_butterfly_stage #(.FFT_N(N), .STAGE(5), .DATA_WIDTH(DW), .TW_WIDTH(16)) dut5 (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
        .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im),
        .y0_re(b_y0_re), .y0_im(b_y0_im), .y1_re(b_y1_re), .y1_im(b_y1_im),
        .out_valid(b_valid), .out_last(b_last)
    );

    function automatic int sat_round(input real v);
        real r;
        r = $floor(v + 0.5);
        if (r > 32767.0)
            r = 32767.0;
        if (r < -32768.0)
            r = -32768.0;
        return $rtoi(r);
    endfunction

    function automatic int mdl_re(input int br, input int bi, input int k);
        real ang;
        ang = 2.0 * PI * real'(k) / real'(N);
        return sat_round(real'(br) * $cos(ang) + real'(bi) * $sin(ang));
    endfunction

    function automatic int mdl_im(input int br, input int bi, input int k);
        real ang;
        ang = 2.0 * PI * real'(k) / real'(N);
        return sat_round(real'(bi) * $cos(ang) - real'(br) * $sin(ang));
    endfunction

    task automatic chk_eq(input string tag, input integer obs, input integer exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input integer obs, input integer exp, input int tol);
        n_assert++;
        assert ((obs >= exp - tol) && (obs <= exp + tol))
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
        end
    endtask

    task automatic chk_outputs(input bit en);
        ent_t e;
        e = pipe[2];
        if (!en) begin
            chk_eq("stall_valid0", a_valid, 0);
            chk_eq("stall_valid5", b_valid, 0);
            chk_eq("stall_last0", a_last, 0);
        end else begin
            chk_eq("valid0", a_valid, e.vld);
            chk_eq("valid5", b_valid, e.vld);
            chk_eq("last0", a_last, e.last);
            chk_eq("last5", b_last, e.last);
            if (e.vld) begin
                chk_eq("y0_re", a_y0_re, e.y0r);
                chk_eq("y0_im", a_y0_im, e.y0i);
                chk_tol("y1_re", a_y1_re, e.y1r, e.tol);
                chk_tol("y1_im", a_y1_im, e.y1i, e.tol);
                chk_eq("s5_y0_re", b_y0_re, e.y0r);
                chk_tol("s5_y1_re", b_y1_re, e.s5r, 1);
                chk_tol("s5_y1_im", b_y1_im, e.s5i, 1);
            end
        end
    endtask

    // One clock: present inputs, advance the expected pipeline, check outputs.
    task automatic cyc(input bit en, input bit v, input int ar, input int ai,
                       input int br, input int bi, input bit hand, input int hr, input int hi);
        ent_t e;
        int dr, di;
        enable   = en;
        in_valid = v;
        x0_re = 16'(ar);
        x0_im = 16'(ai);
        x1_re = 16'(br);
        x1_im = 16'(bi);
        dr = (ar - br) >>> 1;
        di = (ai - bi) >>> 1;
        e.vld  = v;
        e.last = v && (mcnt == N / 2 - 1);
        e.y0r  = (ar + br) >>> 1;
        e.y0i  = (ai + bi) >>> 1;
        e.y1r  = hand ? hr : mdl_re(dr, di, mcnt);
        e.y1i  = hand ? hi : mdl_im(dr, di, mcnt);
        e.s5r  = mdl_re(dr, di, 0);
        e.s5i  = mdl_im(dr, di, 0);
        e.tol  = hand ? 0 : 1;
        @(posedge clk);
        #1;
        if (en) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = e;
            if (v)
                mcnt = (mcnt + 1) % (N / 2);
        end
        chk_outputs(en);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            pipe[i].vld  = 1'b0;
            pipe[i].last = 1'b0;
        end
        mcnt = 0;
    endtask

    initial begin
        reset    = 1'b0;
        enable   = 1'b0;
        in_valid = 1'b0;
        x0_re = '0; x0_im = '0; x1_re = '0; x1_im = '0;
        clear_model();
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_eq("rst_valid", a_valid, 0);
        chk_eq("rst_last", a_last, 0);
        chk_eq("rst_y0_re", a_y0_re, 0);
        chk_eq("rst_y1_re", a_y1_re, 0);
        chk_eq("rst_y1_im", a_y1_im, 0);
        chk_eq("rst_valid5", b_valid, 0);
        reset = 1'b1;

        // Frame 1: constant pair, k sweeps 0..31; hand values at k=0 and k=16.
        for (int i = 0; i < N / 2; i++) begin
            if (i == 6) begin
                cyc(1, 0, 123, -45, 678, 9, 0, 0, 0);
                cyc(1, 0, -7, 300, 5, -11, 0, 0, 0);
            end
            cyc(1, 1, 1000, 0, 200, 0, (i == 0) || (i == 16),
                (i == 16) ? 0 : 400, (i == 16) ? -400 : 0);
        end

        // Frame 2: varied data, a 5-cycle stall, saturation pair at k=16.
        for (int i = 0; i < N / 2; i++) begin
            if (i == 8)
                for (int s = 0; s < 5; s++)
                    cyc(0, 1, 999, 999, -999, -999, 0, 0, 0);
            if (i == 16)
                cyc(1, 1, -32768, -32768, 32767, 32767, 1, -32768, 32767);
            else
                cyc(1, 1, i * 1000 - 16000, 12000 - i * 700,
                    3000 - i * 211, i * 333 - 5000, 0, 0, 0);
        end

        // Frame 3: stop at cnt = 10 and reset between clock edges.
        for (int i = 0; i < 10; i++)
            cyc(1, 1, 500 + i * 37, -200 - i * 51, -300 + i * 13, 100, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk_eq("arst_valid", a_valid, 0);
        chk_eq("arst_last", a_last, 0);
        chk_eq("arst_y0_re", a_y0_re, 0);
        chk_eq("arst_y1_re", a_y1_re, 0);
        chk_eq("arst_y1_im", a_y1_im, 0);
        chk_eq("arst_valid5", b_valid, 0);
        #2;
        reset = 1'b1;
        clear_model();

        cyc(1, 1, 1000, 0, 200, 0, 1, 400, 0);
        for (int i = 0; i < 3; i++)
            cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
